// File: rtl/shift_add_mult8.sv
// Sequential unsigned shift-and-add multiplier: one multiplier bit per clock, 2*WIDTH-bit product.
// Optional early termination when the remaining multiplier bits are zero: SHIFT_ADD_MULT_EARLY_TERM_EN.
module shift_add_mult8 #(
  parameter int WIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   Product,
  output logic                 Busy,
  output logic                 Done
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH-1:0]     lo_sum, hi_sum;
  logic                 lo_cout;
  logic [2*WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]     mplier_shift;
  logic                 last_iter;

  // WIDTH-bit ripple-carry adder: sum and carry-out are split so the
  // high half can drop its carry without leaving dangling bits.
  function automatic logic [WIDTH-1:0] rca_sum(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic             cin);
    logic             c;
    logic [WIDTH-1:0] s;
    c = cin;
    s = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    return s;
  endfunction

  function automatic logic rca_cout(input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b,
                                    input logic             cin);
    logic c;
    c = cin;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    return c;
  endfunction

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  // Add engine: low half first, its carry ripples into the high half.
  always_comb begin
    lo_sum       = rca_sum(acc_q[WIDTH-1:0], mcand_q[WIDTH-1:0], 1'b0);
    lo_cout      = rca_cout(acc_q[WIDTH-1:0], mcand_q[WIDTH-1:0], 1'b0);
    hi_sum       = rca_sum(acc_q[2*WIDTH-1:WIDTH], mcand_q[2*WIDTH-1:WIDTH], lo_cout);
    acc_next     = mplier_q[0] ? {hi_sum, lo_sum} : acc_q;
    mplier_shift = mplier_q >> 1;
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
    last_iter    = (count_q == CW'(WIDTH - 1)) || (mplier_shift == '0);
`else
    last_iter    = (count_q == CW'(WIDTH - 1));
`endif
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    count_d   = count_q;
    product_d = product_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          mcand_d  = {{WIDTH{1'b0}}, A};
          mplier_d = B;
          acc_d    = '0;
          count_d  = '0;
          state_d  = S_RUN;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_shift;
        count_d  = count_q + CW'(1);
        if (last_iter) begin
          product_d = acc_next;
          state_d   = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    Busy    = (state_q == S_RUN);
    Done    = (state_q == S_DONE);
    Product = product_q;
  end

endmodule

// File: tb/tb_shift_add_mult8.sv
// Randomized self-checking bench for shift_add_mult8 against an arithmetic product model.
// Expected busy length follows SHIFT_ADD_MULT_EARLY_TERM_EN when the macro is defined for the build.
module tb_shift_add_mult8;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [15:0] Product;
  logic        Busy;
  logic        Done;

  int unsigned n_checks;
  int unsigned n_errors;
  logic [15:0] last_prod;

  shift_add_mult8 #(.WIDTH(8)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Start   (Start),
    .A       (A),
    .B       (B),
    .Product (Product),
    .Busy    (Busy),
    .Done    (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_busy(input logic [7:0] b);
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
    if (b == 8'h00) return 1;
    for (int i = 7; i >= 0; i--)
      if (b[i]) return i + 1;
    return 1;
`else
    return (b == b) ? 8 : 8;
`endif
  endfunction

  // Called at a negedge; issues Start and confirms acceptance one edge later.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    Start = 1'b1;
    A     = a;
    B     = b;
    @(negedge Clk);
    Start = 1'b0;
    check_val("accept_busy", {31'd0, Busy}, 32'd1);
  endtask

  // Waits for Done, counting Busy cycles; optionally pokes Start/A/B while running.
  task automatic finish_op(input logic [7:0] a, input logic [7:0] b, input bit junk);
    int busy_cnt;
    bit seen;
    busy_cnt = 0;
    seen     = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (Done) begin
        seen = 1'b1;
        break;
      end
      if (Busy) begin
        busy_cnt++;
        check_val("hold_run", {16'd0, Product}, {16'd0, last_prod});
        if (junk) begin
          Start = 1'b1;
          A     = 8'($urandom_range(0, 255));
          B     = 8'($urandom_range(0, 255));
        end
      end
      @(negedge Clk);
    end
    Start = 1'b0;
    check_val("done_seen", {31'd0, seen}, 32'd1);
    check_val("busy_len", busy_cnt, exp_busy(b));
    check_val("busy_at_done", {31'd0, Busy}, 32'd0);
    check_val("product", {16'd0, Product}, 32'(a) * 32'(b));
    last_prod = 16'(32'(a) * 32'(b));
  endtask

  task automatic idle_check();
    @(negedge Clk);
    check_val("done_pulse", {31'd0, Done}, 32'd0);
    check_val("idle_busy", {31'd0, Busy}, 32'd0);
    check_val("idle_hold", {16'd0, Product}, {16'd0, last_prod});
  endtask

  task automatic full_op(input logic [7:0] a, input logic [7:0] b, input bit junk);
    start_op(a, b);
    finish_op(a, b, junk);
    idle_check();
  endtask

  initial begin
    logic [7:0] ra, rb;
    n_checks  = 0;
    n_errors  = 0;
    last_prod = '0;
    Reset = 1'b1;
    Start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    check_val("rst_product", {16'd0, Product}, 32'd0);
    check_val("rst_busy", {31'd0, Busy}, 32'd0);
    check_val("rst_done", {31'd0, Done}, 32'd0);

    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      check_val("idle_quiet", {14'd0, Product, Busy, Done}, 32'd0);
    end

    full_op(8'hFF, 8'hFF, 1'b0);
    full_op(8'h0D, 8'h0B, 1'b1);

    // Back-to-back: second Start presented in the DONE cycle.
    start_op(8'h12, 8'h34);
    finish_op(8'h12, 8'h34, 1'b0);
    start_op(8'h03, 8'h07);
    finish_op(8'h03, 8'h07, 1'b0);
    idle_check();

    // Reset in the middle of RUN discards the partial result and clears Product.
    start_op(8'hAA, 8'h81);
    repeat (3) @(negedge Clk);
    check_val("mid_busy", {31'd0, Busy}, 32'd1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    last_prod = '0;
    check_val("mid_rst_product", {16'd0, Product}, 32'd0);
    check_val("mid_rst_busy", {31'd0, Busy}, 32'd0);
    check_val("mid_rst_done", {31'd0, Done}, 32'd0);
    full_op(8'h02, 8'h03, 1'b0);

    full_op(8'h40, 8'h05, 1'b0);
    full_op(8'h5A, 8'h00, 1'b0);
    full_op(8'h00, 8'hC3, 1'b0);
    full_op(8'h01, 8'h80, 1'b0);

    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255) >> $urandom_range(0, 7));
      start_op(ra, rb);
      finish_op(ra, rb, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_check();
    end
    idle_check();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
